// File: rtl/com_uart_pkg.sv
// Shared UART types, frame constants and bit-period helper.
package com_uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   localparam int   DATA_BITS   = 8;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

   // Bit period in system clocks; callers must keep the result >= 4.
   function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/com_uart_rx.sv
// UART receiver: 2-flop input synchroniser, 8N1 deframer and status flags.
module com_uart_rx
   import com_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic                 clk50M,
   input  logic                 rst_n,
   input  logic                 uart_rxd,
   input  logic                 rx_ack,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_ready,
   output logic                 rx_overrun,
   output logic                 rx_frame_err
);

   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);

   logic                 sync1, sync2, sync_prev;
   uart_state_t          state, state_nx;
   logic [CNT_W-1:0]     cnt, cnt_nx;
   logic [2:0]           bit_idx, bit_idx_nx;
   logic [DATA_BITS-1:0] shift, shift_nx;
   logic                 sample, done, bad_stop;

   // Synchronise the asynchronous line; sync_prev gives the edge history.
   always_ff @(posedge clk50M or negedge rst_n) begin
      if (!rst_n) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         sync_prev <= 1'b1;
      end else begin
         sync1     <= uart_rxd;
         sync2     <= sync1;
         sync_prev <= sync2;
      end
   end

   // Deframer state register.
   always_ff @(posedge clk50M or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         bit_idx <= bit_idx_nx;
         shift   <= shift_nx;
      end
   end

   // Deframer next state: counter runs down to the mid-bit sample point.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      bit_idx_nx = bit_idx;
      shift_nx   = shift;
      done       = 1'b0;
      bad_stop   = 1'b0;
      sample     = (cnt == '0);
      if (state != IDLE)
         cnt_nx = sample ? CNT_MAX : cnt - 1'b1;
      case (state)
         IDLE: begin
            if (!sync2 && sync_prev) begin
               state_nx = START;
               cnt_nx   = CNT_HALF;
            end
         end
         START: begin
            bit_idx_nx = '0;
            if (sample)
               state_nx = (sync2 == START_LEVEL) ? DATA : IDLE;
         end
         DATA: begin
            if (sample) begin
               shift_nx = {sync2, shift[DATA_BITS-1:1]};
               if (bit_idx == 3'(DATA_BITS - 1))
                  state_nx = STOP;
               else
                  bit_idx_nx = bit_idx + 1'b1;
            end
         end
         STOP: begin
            // Leave at the stop mid-sample so a back-to-back start is caught.
            if (sample) begin
               state_nx = IDLE;
               if (sync2 == STOP_LEVEL) done = 1'b1;
               else                     bad_stop = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Holding register and flags; a same-cycle event wins over rx_ack.
   always_ff @(posedge clk50M or negedge rst_n) begin
      if (!rst_n) begin
         rx_data      <= '0;
         rx_ready     <= 1'b0;
         rx_overrun   <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         if (done) begin
            rx_data  <= shift;
            rx_ready <= 1'b1;
         end else if (rx_ack) begin
            rx_ready <= 1'b0;
         end
         if (done && rx_ready) rx_overrun <= 1'b1;
         else if (rx_ack)      rx_overrun <= 1'b0;
         if (bad_stop)         rx_frame_err <= 1'b1;
         else if (rx_ack)      rx_frame_err <= 1'b0;
      end
   end

endmodule

// File: rtl/com_uart.sv
// COM port UART: 8N1 transmitter FSM plus the receiver sub-module.
module com_uart
   import com_uart_pkg::*;
#(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 115200
) (
   input  logic                 clk50M,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_start,
   output logic                 tx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_ready,
   input  logic                 rx_ack,
   output logic                 rx_overrun,
   output logic                 rx_frame_err,
   output logic                 uart_txd,
   input  logic                 uart_rxd
);

   localparam int               CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
   localparam int               CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(CLKS_PER_BIT - 1);

   uart_state_t          tx_state, tx_state_nx;
   logic [CNT_W-1:0]     tx_cnt, tx_cnt_nx;
   logic [2:0]           tx_bit, tx_bit_nx;
   logic [DATA_BITS-1:0] tx_shift, tx_shift_nx;
   logic                 txd, txd_nx;
   logic                 bit_end;

   // Transmitter state register; line goes high immediately on reset.
   always_ff @(posedge clk50M or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         txd      <= 1'b1;
      end else begin
         tx_state <= tx_state_nx;
         tx_cnt   <= tx_cnt_nx;
         tx_bit   <= tx_bit_nx;
         tx_shift <= tx_shift_nx;
         txd      <= txd_nx;
      end
   end

   // Transmitter next state; the line level is registered with the state.
   always_comb begin
      tx_state_nx = tx_state;
      tx_cnt_nx   = tx_cnt;
      tx_bit_nx   = tx_bit;
      tx_shift_nx = tx_shift;
      txd_nx      = txd;
      bit_end     = (tx_cnt == CNT_MAX);
      if (tx_state != IDLE)
         tx_cnt_nx = bit_end ? '0 : tx_cnt + 1'b1;
      case (tx_state)
         IDLE: begin
            // Strobes are only honoured here, so a busy frame is never disturbed.
            if (tx_start) begin
               tx_state_nx = START;
               tx_cnt_nx   = '0;
               tx_shift_nx = tx_data;
               txd_nx      = START_LEVEL;
            end
         end
         START: begin
            if (bit_end) begin
               tx_state_nx = DATA;
               tx_bit_nx   = '0;
               txd_nx      = tx_shift[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (tx_bit == 3'(DATA_BITS - 1)) begin
                  tx_state_nx = STOP;
                  txd_nx      = STOP_LEVEL;
               end else begin
                  tx_bit_nx   = tx_bit + 1'b1;
                  tx_shift_nx = tx_shift >> 1;
                  txd_nx      = tx_shift[1];
               end
            end
         end
         STOP: begin
            if (bit_end)
               tx_state_nx = IDLE;
         end
         default: tx_state_nx = IDLE;
      endcase
   end

   assign tx_ready = (tx_state == IDLE);
   assign uart_txd = txd;

   com_uart_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk50M       (clk50M),
      .rst_n        (rst_n),
      .uart_rxd     (uart_rxd),
      .rx_ack       (rx_ack),
      .rx_data      (rx_data),
      .rx_ready     (rx_ready),
      .rx_overrun   (rx_overrun),
      .rx_frame_err (rx_frame_err)
   );

endmodule

// File: tb/tb_com_uart.sv
// Self-checking bench for com_uart at 8 clocks per bit.
module tb_com_uart;

   localparam int CPB = 8;

   logic       clk50M = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_start = 1'b0;
   logic       rx_ack = 1'b0;
   logic       rxd_drv = 1'b1;
   logic       loop = 1'b0;
   logic       tx_ready, rx_ready, rx_overrun, rx_frame_err, uart_txd, uart_rxd;
   logic [7:0] rx_data;

   int n_assert = 0;
   int n_fail = 0;

   // Reference model of the receive holding register and flags.
   logic [7:0] m_data = '0;
   logic       m_ready = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;

   assign uart_rxd = loop ? uart_txd : rxd_drv;

   com_uart #(
      .CLK_HZ (50000000),
      .BAUD   (6250000)
   ) dut (
      .clk50M       (clk50M),
      .rst_n        (rst_n),
      .tx_data      (tx_data),
      .tx_start     (tx_start),
      .tx_ready     (tx_ready),
      .rx_data      (rx_data),
      .rx_ready     (rx_ready),
      .rx_ack       (rx_ack),
      .rx_overrun   (rx_overrun),
      .rx_frame_err (rx_frame_err),
      .uart_txd     (uart_txd),
      .uart_rxd     (uart_rxd)
   );

   always #5 clk50M = ~clk50M;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Line level of bit k of an 8N1 frame carrying b.
   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return b[k-1];
   endfunction

   function automatic void m_rx(input logic [7:0] b, input logic stop_ok);
      if (stop_ok) begin
         m_ovr   = m_ovr | m_ready;
         m_ready = 1'b1;
         m_data  = b;
      end else begin
         m_ferr = 1'b1;
      end
   endfunction

   task automatic check_rx(input string tag);
      chk({tag, ".data"}, rx_data, m_data);
      chk({tag, ".ready"}, rx_ready, m_ready);
      chk({tag, ".ovr"}, rx_overrun, m_ovr);
      chk({tag, ".ferr"}, rx_frame_err, m_ferr);
   endtask

   task automatic ack(input int n);
      rx_ack = 1'b1;
      repeat (n) @(negedge clk50M);
      rx_ack = 1'b0;
      m_ready = 1'b0;
      m_ovr   = 1'b0;
      m_ferr  = 1'b0;
   endtask

   // Drives one frame on the RX pin; first = stop-bit clock where rx_ready was first seen.
   task automatic drive_rx(input logic [7:0] b, input logic stop, output int first);
      first = -1;
      for (int k = 0; k < 9; k++) begin
         rxd_drv = frame_bit(b, k);
         repeat (CPB) @(negedge clk50M);
      end
      rxd_drv = stop;
      for (int j = 0; j < CPB; j++) begin
         @(negedge clk50M);
         if (rx_ready && first < 0) first = j;
      end
      rxd_drv = 1'b1;
   endtask

   // Sends one byte and checks every clock of the TX waveform and tx_ready.
   task automatic tx_send(input logic [7:0] b, input logic inject);
      tx_data  = b;
      tx_start = 1'b1;
      @(negedge clk50M);
      tx_start = 1'b0;
      for (int i = 0; i < 10 * CPB; i++) begin
         chk($sformatf("txd[%0d]", i), uart_txd, frame_bit(b, i / CPB));
         chk($sformatf("tx_busy[%0d]", i), tx_ready, 1'b0);
         if (inject && i == 20) begin
            tx_data  = 8'h3C;
            tx_start = 1'b1;
         end
         if (inject && i == 21) tx_start = 1'b0;
         @(negedge clk50M);
      end
      chk("tx_ready_rise", tx_ready, 1'b1);
      chk("tx_idle_line", uart_txd, 1'b1);
   endtask

   initial begin
      int first;
      logic [7:0] b;

      // Reset state.
      repeat (3) @(negedge clk50M);
      chk("rst.txd", uart_txd, 1'b1);
      chk("rst.tx_ready", tx_ready, 1'b1);
      check_rx("rst");
      rst_n = 1'b1;
      repeat (3) @(negedge clk50M);

      // Plain transmit, then transmit with an ignored mid-frame strobe.
      tx_send(8'hA5, 1'b0);
      repeat (2) @(negedge clk50M);
      tx_send(8'hA5, 1'b1);
      @(negedge clk50M);
      chk("no_queue.tx_ready", tx_ready, 1'b1);
      chk("no_queue.txd", uart_txd, 1'b1);

      // Receive with latency check, then a multi-cycle ack.
      drive_rx(8'h5A, 1'b1, first);
      chk("rx_latency_ok", (first >= 3 && first <= 7), 1'b1);
      m_rx(8'h5A, 1'b1);
      repeat (2) @(negedge clk50M);
      check_rx("rx5a");
      ack(3);
      check_rx("rx5a_ack");

      // Back-to-back frames without ack -> overrun.
      drive_rx(8'h11, 1'b1, first);
      m_rx(8'h11, 1'b1);
      drive_rx(8'h22, 1'b1, first);
      m_rx(8'h22, 1'b1);
      repeat (2) @(negedge clk50M);
      check_rx("overrun");
      ack(1);
      check_rx("overrun_ack");

      // Stop bit low -> frame error only.
      drive_rx(8'h77, 1'b0, first);
      m_rx(8'h77, 1'b0);
      repeat (2) @(negedge clk50M);
      check_rx("frame_err");
      ack(1);
      check_rx("frame_err_ack");

      // Short low glitch on idle line.
      rxd_drv = 1'b0;
      repeat (3) @(negedge clk50M);
      rxd_drv = 1'b1;
      repeat (100) @(negedge clk50M);
      check_rx("glitch");

      // Random bytes through loopback, random acks between them.
      loop = 1'b1;
      for (int n = 0; n < 6; n++) begin
         b = 8'($urandom);
         if ($urandom_range(0, 1) == 1) ack(1);
         tx_send(b, 1'b0);
         m_rx(b, 1'b1);
         repeat (2) @(negedge clk50M);
         check_rx($sformatf("loop%0d", n));
      end

      // Reset in the middle of a loopback frame.
      tx_data  = 8'hC3;
      tx_start = 1'b1;
      @(negedge clk50M);
      tx_start = 1'b0;
      repeat (40) @(negedge clk50M);
      #2 rst_n = 1'b0;
      #1;
      m_data = '0; m_ready = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
      chk("midrst.txd", uart_txd, 1'b1);
      chk("midrst.tx_ready", tx_ready, 1'b1);
      check_rx("midrst");
      @(negedge clk50M);
      rst_n = 1'b1;
      repeat (5) @(negedge clk50M);
      check_rx("post_rst_idle");
      tx_send(8'hC3, 1'b0);
      m_rx(8'hC3, 1'b1);
      repeat (2) @(negedge clk50M);
      check_rx("post_rst_c3");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
